// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration loader.
// Frame header layout: tile id in the top bits, broadcast flag just below.
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_e;

    localparam int CFG_FRAME_WIDTH   = 64;
    localparam int CFG_TILE_ID_WIDTH = 4;

    function automatic int tile_id_lsb(input int frame_width, input int tile_id_width);
        return frame_width - tile_id_width;
    endfunction

    function automatic int bcast_pos(input int frame_width, input int tile_id_width);
        return frame_width - tile_id_width - 1;
    endfunction

    localparam int CFG_TILE_ID_LSB = tile_id_lsb(CFG_FRAME_WIDTH, CFG_TILE_ID_WIDTH);
    localparam int CFG_BCAST_POS   = bcast_pos(CFG_FRAME_WIDTH, CFG_TILE_ID_WIDTH);

endpackage

// File: rtl/cgra_cfg_decode.sv
// Combinational frame header decode: per-tile strobe vector and an
// out-of-range flag for unicast frames addressing a missing tile.
module cgra_cfg_decode
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_TILES     = 16,
    parameter int FRAME_WIDTH   = CFG_FRAME_WIDTH,
    parameter int TILE_ID_WIDTH = CFG_TILE_ID_WIDTH
) (
    input  logic [FRAME_WIDTH-1:0] frame,
    output logic [NUM_TILES-1:0]   config_valid,
    output logic                   out_of_range
);

    localparam int ID_LSB = tile_id_lsb(FRAME_WIDTH, TILE_ID_WIDTH);
    localparam int BC_POS = bcast_pos(FRAME_WIDTH, TILE_ID_WIDTH);

    logic [TILE_ID_WIDTH-1:0] tile_id_s;
    logic                     bcast_s;
    logic                     unused_payload_s;

    assign tile_id_s        = frame[ID_LSB +: TILE_ID_WIDTH];
    assign bcast_s          = frame[BC_POS];
    assign unused_payload_s = ^frame[BC_POS-1:0];

    // Strobe generation: broadcast wins, otherwise one-hot (empty if out of range)
    always_comb begin
        config_valid = '0;
        out_of_range = 1'b0;
        if (bcast_s) begin
            config_valid = '1;
        end else begin
            out_of_range = (32'(tile_id_s) >= 32'(NUM_TILES));
            for (int i = 0; i < NUM_TILES; i++) begin
                config_valid[i] = (32'(tile_id_s) == 32'(i));
            end
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams config frames from memory to CGRA tiles, one frame every three
// cycles (FETCH -> WAIT -> ISSUE), with abort and sticky error handling.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_TILES      = 16,
    parameter int FRAME_WIDTH    = CFG_FRAME_WIDTH,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int TILE_ID_WIDTH  = CFG_TILE_ID_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM_ADDR_WIDTH:0]   num_frames,
    input  logic                      abort,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [FRAME_WIDTH-1:0]    mem_rd_data,
    output logic [FRAME_WIDTH-1:0]    config_frame,
    output logic [NUM_TILES-1:0]      config_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [MEM_ADDR_WIDTH:0]   frames_sent
);

    localparam int CW = MEM_ADDR_WIDTH + 1;

    cfg_state_e                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]             num_q, num_d;
    logic [CW-1:0]             frames_sent_q, frames_sent_d;
    logic                      mem_rd_en_q, mem_rd_en_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [FRAME_WIDTH-1:0]    config_frame_q, config_frame_d;
    logic [NUM_TILES-1:0]      config_valid_q, config_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic [NUM_TILES-1:0]      dec_valid_s;
    logic                      dec_oor_s;

    cgra_cfg_decode #(
        .NUM_TILES     (NUM_TILES),
        .FRAME_WIDTH   (FRAME_WIDTH),
        .TILE_ID_WIDTH (TILE_ID_WIDTH)
    ) u_decode (
        .frame        (mem_rd_data),
        .config_valid (dec_valid_s),
        .out_of_range (dec_oor_s)
    );

    // Next-state and next-output logic; abort outranks every transition
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        num_d          = num_q;
        frames_sent_d  = frames_sent_q;
        mem_rd_en_d    = 1'b0;
        mem_rd_addr_d  = mem_rd_addr_q;
        config_frame_d = config_frame_q;
        config_valid_d = '0;
        done_d         = 1'b0;
        error_d        = error_q;

        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_d        = base_addr;
                        num_d         = num_frames;
                        frames_sent_d = '0;
                        error_d       = 1'b0;
                        if (num_frames == CW'(0)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d       = ST_FETCH;
                            mem_rd_en_d   = 1'b1;
                            mem_rd_addr_d = base_addr;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (dec_oor_s) begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d        = ST_ISSUE;
                        config_frame_d = mem_rd_data;
                        config_valid_d = dec_valid_s;
                    end
                end
                ST_ISSUE: begin
                    frames_sent_d = frames_sent_q + CW'(1);
                    if (frames_sent_d == num_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Address arithmetic wraps naturally at the memory size
                        state_d       = ST_FETCH;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = base_q + frames_sent_d[MEM_ADDR_WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            num_q          <= '0;
            frames_sent_q  <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            config_frame_q <= '0;
            config_valid_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            num_q          <= num_d;
            frames_sent_q  <= frames_sent_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            config_frame_q <= config_frame_d;
            config_valid_q <= config_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_rd_addr  = mem_rd_addr_q;
    assign config_frame = config_frame_q;
    assign config_valid = config_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed self-checking bench: a 16-tile loader for the main scenarios and a
// 12-tile loader for the out-of-range tile-id case, sharing one config memory.
module tb_cgra_config_loader;

    logic        clk;
    logic        rst;
    logic        start16, start12;
    logic [7:0]  base_addr;
    logic [8:0]  num_frames;
    logic        abort;

    logic        rden16, rden12;
    logic [7:0]  addr16, addr12;
    logic [63:0] rdata16, rdata12;
    logic [63:0] frame16, frame12;
    logic [15:0] cv16;
    logic [11:0] cv12;
    logic        busy16, busy12, done16, done12, err16, err12;
    logic [8:0]  fs16, fs12;

    logic [63:0] mem [256];

    int checks;
    int errors;

    cgra_config_loader dut16 (
        .clk(clk), .rst(rst), .start(start16), .base_addr(base_addr),
        .num_frames(num_frames), .abort(abort), .mem_rd_en(rden16),
        .mem_rd_addr(addr16), .mem_rd_data(rdata16), .config_frame(frame16),
        .config_valid(cv16), .busy(busy16), .done(done16), .error(err16),
        .frames_sent(fs16)
    );

    cgra_config_loader #(.NUM_TILES(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .base_addr(base_addr),
        .num_frames(num_frames), .abort(abort), .mem_rd_en(rden12),
        .mem_rd_addr(addr12), .mem_rd_data(rdata12), .config_frame(frame12),
        .config_valid(cv12), .busy(busy12), .done(done12), .error(err12),
        .frames_sent(fs12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config memory with one-cycle read latency, one read port per loader
    always @(posedge clk) begin
        if (rden16) rdata16 <= mem[addr16];
        if (rden12) rdata12 <= mem[addr12];
    end

    function automatic logic [63:0] mk(input logic [3:0] t, input logic b, input logic [58:0] p);
        return {t, b, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ev16;
    logic [11:0] ev12;
    logic [63:0] f0, f1, f2, w0, w1, w2, g0, g1;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start16 = 1'b0; start12 = 1'b0; abort = 1'b0;
        base_addr = 8'h00; num_frames = 9'd0;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        f0 = mk(4'd0, 1'b0, 59'h0A0A); f1 = mk(4'd5, 1'b0, 59'h0B0B); f2 = mk(4'd15, 1'b0, 59'h0C0C);
        w0 = mk(4'd1, 1'b0, 59'h1111); w1 = mk(4'd2, 1'b1, 59'h2222); w2 = mk(4'd7, 1'b0, 59'h3333);
        g0 = mk(4'd3, 1'b0, 59'h4444); g1 = mk(4'd13, 1'b0, 59'h5555);
        mem[8'h10] = f0; mem[8'h11] = f1; mem[8'h12] = f2;
        mem[8'hFE] = w0; mem[8'hFF] = w1; mem[8'h00] = w2;
        mem[8'h20] = g0; mem[8'h21] = g1;
        rdata16 = 64'h0; rdata12 = 64'h0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy16), 64'(0));
        check("rst_done", 64'(done16), 64'(0));
        check("rst_error", 64'(err16), 64'(0));
        check("rst_rden", 64'(rden16), 64'(0));
        check("rst_valid", 64'(cv16), 64'(0));
        check("rst_frame", frame16, 64'(0));
        check("rst_addr", 64'(addr16), 64'(0));
        check("rst_fsent", 64'(fs16), 64'(0));
        tick();

        // Three unicast frames from 0x10: tiles 0, 5, 15
        base_addr = 8'h10; num_frames = 9'd3; start16 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick(); start16 = 1'b0;
            ev16 = (c == 3) ? 16'h0001 : (c == 6) ? 16'h0020 : (c == 9) ? 16'h8000 : 16'h0000;
            check("s1_valid", 64'(cv16), 64'(ev16));
            check("s1_done", 64'(done16), 64'(c == 10));
            check("s1_rden", 64'(rden16), 64'(c == 1 || c == 4 || c == 7));
            check("s1_busy", 64'(busy16), 64'(c <= 10));
            if (c == 1) check("s1_addr0", 64'(addr16), 64'h10);
            if (c == 4) check("s1_addr1", 64'(addr16), 64'h11);
            if (c == 7) check("s1_addr2", 64'(addr16), 64'h12);
            if (c == 3 || c == 5) check("s1_frame0", frame16, f0);
            if (c == 9) check("s1_frame2", frame16, f2);
        end
        check("s1_fsent", 64'(fs16), 64'(3));
        check("s1_error", 64'(err16), 64'(0));
        tick();

        // Wrapping addresses, broadcast middle frame, start while busy ignored
        base_addr = 8'hFE; num_frames = 9'd3; start16 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick(); start16 = 1'b0;
            ev16 = (c == 3) ? 16'h0002 : (c == 6) ? 16'hFFFF : (c == 9) ? 16'h0080 : 16'h0000;
            check("s2_valid", 64'(cv16), 64'(ev16));
            check("s2_done", 64'(done16), 64'(c == 10));
            if (c == 1) check("s2_addr0", 64'(addr16), 64'hFE);
            if (c == 4) check("s2_addr1", 64'(addr16), 64'hFF);
            if (c == 7) check("s2_addr2", 64'(addr16), 64'h00);
            if (c == 6) check("s2_bframe", frame16, w1);
            if (c == 2) begin
                base_addr = 8'h40; num_frames = 9'd1; start16 = 1'b1;
            end
        end
        check("s2_fsent", 64'(fs16), 64'(3));
        tick();

        // Zero-frame load: done one cycle after start, no reads, no strobes
        num_frames = 9'd0; base_addr = 8'h10; start16 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(); start16 = 1'b0;
            check("s3_done", 64'(done16), 64'(c == 1));
            check("s3_busy", 64'(busy16), 64'(c == 1));
            check("s3_rden", 64'(rden16), 64'(0));
            check("s3_valid", 64'(cv16), 64'(0));
        end
        check("s3_fsent", 64'(fs16), 64'(0));

        // Abort during WAIT of frame 2
        base_addr = 8'h10; num_frames = 9'd3; start16 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(); start16 = 1'b0; abort = 1'b0;
            check("ab_valid", 64'(cv16), 64'((c == 3) ? 16'h0001 : 16'h0000));
            check("ab_done", 64'(done16), 64'(0));
            check("ab_rden", 64'(rden16), 64'(c == 1 || c == 4));
            check("ab_busy", 64'(busy16), 64'(c <= 5));
            check("ab_error", 64'(err16), 64'(c >= 6));
            if (c == 5) abort = 1'b1;
        end
        check("ab_fsent", 64'(fs16), 64'(1));

        // Abort while idle changes nothing
        abort = 1'b1; tick(); abort = 1'b0; tick();
        check("ai_busy", 64'(busy16), 64'(0));
        check("ai_error", 64'(err16), 64'(1));
        check("ai_fsent", 64'(fs16), 64'(1));

        // Reset in FETCH of frame 2
        base_addr = 8'h10; num_frames = 9'd3; start16 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick(); start16 = 1'b0;
            if (c == 1) check("rm_errclr", 64'(err16), 64'(0));
            if (c == 4) check("rm_rden", 64'(rden16), 64'(1));
            if (c == 5) begin
                rst = 1'b0;
                check("rm_frame", frame16, 64'(0));
                check("rm_addr", 64'(addr16), 64'(0));
                check("rm_fsent", 64'(fs16), 64'(0));
                check("rm_rden0", 64'(rden16), 64'(0));
            end
            if (c >= 5) begin
                check("rm_valid", 64'(cv16), 64'(0));
                check("rm_done", 64'(done16), 64'(0));
                check("rm_busy", 64'(busy16), 64'(0));
                check("rm_error", 64'(err16), 64'(0));
            end
            if (c == 4) rst = 1'b1;
        end

        // 12-tile loader: second frame addresses tile 13
        base_addr = 8'h20; num_frames = 9'd3; start12 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick(); start12 = 1'b0;
            ev12 = (c == 3) ? 12'h008 : 12'h000;
            check("oor_valid", 64'(cv12), 64'(ev12));
            check("oor_done", 64'(done12), 64'(0));
            check("oor_busy", 64'(busy12), 64'(c <= 5));
            check("oor_error", 64'(err12), 64'(c >= 6));
            if (c == 3) check("oor_frame", frame12, g0);
        end
        check("oor_fsent", 64'(fs12), 64'(1));
        check("oor_frame_hold", frame12, g0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
